// File: rtl/i2c_slave_core.sv
// I2C target with an 8x8 register file plus a cs/read/write host port; pin events act 3 clk after the pin changes.
// No backpressure: SCL is never stretched, and host accesses complete in one cycle.
module i2c_slave_core #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  reg_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        scl,
  inout  wire         sda
);

  typedef enum logic [2:0] {IDLE, ADDR, PTR, RX, TX} state_t;

  state_t      state;
  logic        scl_s1, scl_s2, scl_d;
  logic        sda_s1, sda_s2, sda_d;
  logic [3:0]  bitcnt;
  logic [7:0]  shreg;
  logic [7:0]  txsh;
  logic [2:0]  ptr;
  logic        rx_flag;
  logic        busy;
  logic        sda_oe;
  logic [7:0]  regfile [8];

  logic        scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0]  rx_byte;
  logic        unused;

  assign scl_rise = scl_s2 & ~scl_d;
  assign scl_fall = ~scl_s2 & scl_d;
  assign start_ev = scl_s2 & sda_d & ~sda_s2;
  assign stop_ev  = scl_s2 & ~sda_d & sda_s2;
  assign rx_byte  = {shreg[6:0], sda_s2};
  assign sda      = sda_oe ? 1'b0 : 1'bz;
  assign unused   = ^{read, wr_data[31:8]};

  always_comb begin
    rd_data = '0;
    if (reg_addr[4:3] == 2'b00)
      rd_data[7:0] = regfile[reg_addr[2:0]];
    else if (reg_addr == 5'd8)
      rd_data = {25'b0, ptr, 2'b0, rx_flag, busy};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_s1  <= 1'b1;
      scl_s2  <= 1'b1;
      scl_d   <= 1'b1;
      sda_s1  <= 1'b1;
      sda_s2  <= 1'b1;
      sda_d   <= 1'b1;
      state   <= IDLE;
      bitcnt  <= '0;
      shreg   <= '0;
      txsh    <= '0;
      ptr     <= '0;
      rx_flag <= 1'b0;
      busy    <= 1'b0;
      sda_oe  <= 1'b0;
      for (int i = 0; i < 8; i++) regfile[i] <= 8'h00;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;

      // Host updates come first so that same-cycle I2C updates below override them.
      if (cs && write) begin
        if (reg_addr[4:3] == 2'b00)
          regfile[reg_addr[2:0]] <= wr_data[7:0];
        else if (reg_addr == 5'd8)
          rx_flag <= 1'b0;
      end

      if (start_ev) begin
        state  <= ADDR;
        bitcnt <= '0;
        sda_oe <= 1'b0;
      end else if (stop_ev) begin
        state  <= IDLE;
        bitcnt <= '0;
        busy   <= 1'b0;
        sda_oe <= 1'b0;
      end else if (state != IDLE) begin
        if (scl_rise) begin
          if (bitcnt < 4'd8) begin
            shreg  <= rx_byte;
            bitcnt <= bitcnt + 4'd1;
            if (state == RX && bitcnt == 4'd7) begin
              regfile[ptr] <= rx_byte;
              rx_flag      <= 1'b1;
              ptr          <= ptr + 3'd1;
            end
          end else if (bitcnt == 4'd8) begin
            bitcnt <= 4'd9;
            if (state == TX) begin
              if (sda_s2) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                ptr <= ptr + 3'd1;
              end
            end
          end
        end else if (scl_fall) begin
          if (bitcnt == 4'd8) begin
            case (state)
              ADDR: begin
                if (shreg[7:1] == SLAVE_ADDR) begin
                  sda_oe <= 1'b1;
                  busy   <= 1'b1;
                end else begin
                  state <= IDLE;
                end
              end
              PTR: begin
                sda_oe <= 1'b1;
                ptr    <= shreg[2:0];
              end
              RX:      sda_oe <= 1'b1;
              TX:      sda_oe <= 1'b0;
              default: sda_oe <= 1'b0;
            endcase
          end else if (bitcnt == 4'd9) begin
            // End of the ACK clock: shreg still holds the address byte, so bit 0 is R/W.
            bitcnt <= '0;
            sda_oe <= 1'b0;
            if ((state == ADDR && shreg[0]) || state == TX) begin
              state  <= TX;
              sda_oe <= ~regfile[ptr][7];
              txsh   <= {regfile[ptr][6:0], 1'b0};
            end else if (state == ADDR) begin
              state <= PTR;
            end else if (state == PTR) begin
              state <= RX;
            end
          end else if (state == TX && bitcnt != 4'd0) begin
            sda_oe <= ~txsh[7];
            txsh   <= {txsh[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule
